// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment driver: one digit per scan event, with a
// blanking gap before each digit and registered, snapshot-based segment decode.
module seven_seg_scan #(
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_tick,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic [3:0]  digit_en,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic [1:0]  digit_sel
);

    localparam logic [7:0] LAST_BLANK = 8'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } state_t;

    state_t      state, state_nx;
    logic        tick_q;
    logic        scan_event;
    logic [7:0]  blank_cnt, blank_cnt_nx;
    logic [1:0]  sel_nx;
    logic [15:0] value_q, value_nx;
    logic [3:0]  dp_q, dp_nx;
    logic [3:0]  en_q, en_nx;
    logic        lz_q, lz_nx;
    logic [3:0]  an_nx;
    logic [6:0]  seg_nx;
    logic        dp_n_nx;
    logic [3:0]  nibble;
    logic        upper_zero;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_glyph = 7'b1000000;
            4'h1:    hex_glyph = 7'b1111001;
            4'h2:    hex_glyph = 7'b0100100;
            4'h3:    hex_glyph = 7'b0110000;
            4'h4:    hex_glyph = 7'b0011001;
            4'h5:    hex_glyph = 7'b0010010;
            4'h6:    hex_glyph = 7'b0000010;
            4'h7:    hex_glyph = 7'b1111000;
            4'h8:    hex_glyph = 7'b0000000;
            4'h9:    hex_glyph = 7'b0010000;
            4'hA:    hex_glyph = 7'b0001000;
            4'hB:    hex_glyph = 7'b0000011;
            4'hC:    hex_glyph = 7'b1000110;
            4'hD:    hex_glyph = 7'b0100001;
            4'hE:    hex_glyph = 7'b0000110;
            default: hex_glyph = 7'b0001110;
        endcase
    endfunction

    assign scan_event = scan_tick & ~tick_q;

    // Scan sequencing; events arriving while blanking are deliberately ignored.
    always_comb begin
        state_nx     = state;
        blank_cnt_nx = blank_cnt;
        sel_nx       = digit_sel;
        value_nx     = value_q;
        dp_nx        = dp_q;
        en_nx        = en_q;
        lz_nx        = lz_q;
        case (state)
            IDLE: begin
                if (scan_event) begin
                    state_nx     = BLANK;
                    blank_cnt_nx = 8'd0;
                end
            end
            BLANK: begin
                if (blank_cnt == LAST_BLANK) begin
                    state_nx = DRIVE;
                    sel_nx   = digit_sel + 2'd1;
                    value_nx = value;
                    dp_nx    = dp;
                    en_nx    = digit_en;
                    lz_nx    = blank_lz;
                end else begin
                    blank_cnt_nx = blank_cnt + 8'd1;
                end
            end
            DRIVE: begin
                if (scan_event) begin
                    state_nx     = BLANK;
                    blank_cnt_nx = 8'd0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are decoded from next-state values so the registered drive lines
    // change on the same edge the FSM enters DRIVE.
    always_comb begin
        an_nx   = 4'hF;
        seg_nx  = 7'h7F;
        dp_n_nx = 1'b1;
        nibble  = value_nx[{sel_nx, 2'b00} +: 4];
        case (sel_nx)
            2'd1:    upper_zero = (value_nx[15:4] == 12'h000);
            2'd2:    upper_zero = (value_nx[15:8] == 8'h00);
            2'd3:    upper_zero = (value_nx[15:12] == 4'h0);
            default: upper_zero = 1'b0;
        endcase
        if (state_nx == DRIVE && en_nx[sel_nx]) begin
            an_nx   = ~(4'b0001 << sel_nx);
            dp_n_nx = ~dp_nx[sel_nx];
            seg_nx  = (lz_nx && upper_zero) ? 7'h7F : hex_glyph(nibble);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            tick_q    <= 1'b0;
            blank_cnt <= 8'd0;
            digit_sel <= 2'd3;
            value_q   <= 16'h0000;
            dp_q      <= 4'h0;
            en_q      <= 4'h0;
            lz_q      <= 1'b0;
            an        <= 4'hF;
            seg       <= 7'h7F;
            dp_n      <= 1'b1;
        end else begin
            state     <= state_nx;
            tick_q    <= scan_tick;
            blank_cnt <= blank_cnt_nx;
            digit_sel <= sel_nx;
            value_q   <= value_nx;
            dp_q      <= dp_nx;
            en_q      <= en_nx;
            lz_q      <= lz_nx;
            an        <= an_nx;
            seg       <= seg_nx;
            dp_n      <= dp_n_nx;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: directed scenarios plus random traffic, every cycle
// compared against a time-based model of the scanned display.
module tb_seven_seg_scan;

    localparam int BLANK = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        scan_tick;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic [1:0]  digit_sel;

    int checks_total  = 0;
    int checks_passed = 0;
    int cyc = 0;

    logic [6:0] glyph_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model: which digit is up, what was latched for it, and when blanking ends.
    logic        m_prev_tick;
    logic        m_showing;
    int          m_blank_end;
    int          m_sel;
    logic [15:0] m_val;
    logic [3:0]  m_dp, m_en;
    logic        m_lz;

    seven_seg_scan #(.BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .rst(rst), .scan_tick(scan_tick), .value(value), .dp(dp),
        .digit_en(digit_en), .blank_lz(blank_lz), .an(an), .seg(seg),
        .dp_n(dp_n), .digit_sel(digit_sel)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got !== exp)
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        else
            checks_passed++;
    endtask

    task automatic applyStimulus(input int n);
        logic       ev;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dpn;
        logic [3:0] nib;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            cyc++;
            if (!rst) begin
                m_prev_tick = 1'b0;
                m_showing   = 1'b0;
                m_blank_end = -1;
                m_sel       = 3;
                m_val = 16'h0; m_dp = 4'h0; m_en = 4'h0; m_lz = 1'b0;
            end else begin
                ev          = scan_tick && !m_prev_tick;
                m_prev_tick = scan_tick;
                if (m_blank_end >= 0) begin
                    if (cyc == m_blank_end) begin
                        m_blank_end = -1;
                        m_showing   = 1'b1;
                        m_sel       = (m_sel + 1) % 4;
                        m_val = value; m_dp = dp; m_en = digit_en; m_lz = blank_lz;
                    end
                end else if (ev) begin
                    m_blank_end = cyc + BLANK;
                    m_showing   = 1'b0;
                end
            end
            e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1;
            if (m_showing && m_en[m_sel]) begin
                nib   = 4'((m_val >> (4 * m_sel)) & 16'hF);
                e_an  = 4'hF ^ (4'b0001 << m_sel);
                e_dpn = !m_dp[m_sel];
                if (!(m_lz && m_sel > 0 && (m_val >> (4 * m_sel)) == 0))
                    e_seg = glyph_tbl[nib];
            end
            #1;
            checkOutput("an", 32'(an), 32'(e_an));
            checkOutput("seg", 32'(seg), 32'(e_seg));
            checkOutput("dp_n", 32'(dp_n), 32'(e_dpn));
            checkOutput("digit_sel", 32'(digit_sel), 32'(m_sel));
        end
    endtask

    // One scan event followed by the full blanking gap, ending on the first drive cycle.
    task automatic scanDigit(input string tag);
        scan_tick = 1'b1;
        applyStimulus(1);
        checkOutput({tag, "_gap"}, 32'(an), 32'hF);
        scan_tick = 1'b0;
        for (int j = 1; j < BLANK; j++) begin
            applyStimulus(1);
            checkOutput({tag, "_gap"}, 32'(an), 32'hF);
        end
        applyStimulus(1);
    endtask

    initial begin
        logic [3:0] exp_an [4];
        logic [6:0] exp_seg [4];
        exp_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
        exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79};

        rst = 1'b0; scan_tick = 1'b0; value = 16'h1234; dp = 4'h0;
        digit_en = 4'hF; blank_lz = 1'b0;
        applyStimulus(3);
        checkOutput("rst_an", 32'(an), 32'hF);
        checkOutput("rst_seg", 32'(seg), 32'h7F);
        checkOutput("rst_dpn", 32'(dp_n), 32'h1);
        checkOutput("rst_sel", 32'(digit_sel), 32'h3);
        rst = 1'b1;
        applyStimulus(2);

        for (int d = 0; d < 4; d++) begin
            scanDigit("scan1234");
            checkOutput("scan1234_an", 32'(an), 32'(exp_an[d]));
            checkOutput("scan1234_seg", 32'(seg), 32'(exp_seg[d]));
            checkOutput("scan1234_sel", 32'(digit_sel), 32'(d));
            applyStimulus(100 - 17);
        end

        scanDigit("wrap");
        checkOutput("wrap_sel", 32'(digit_sel), 32'h0);
        checkOutput("wrap_an", 32'(an), 32'hE);
        applyStimulus(20);
        scan_tick = 1'b1;
        applyStimulus(1000);
        checkOutput("hold_sel", 32'(digit_sel), 32'h1);
        checkOutput("hold_an", 32'(an), 32'hD);
        scan_tick = 1'b0;
        applyStimulus(5);

        value = 16'h0050; blank_lz = 1'b1;
        scanDigit("lz");
        checkOutput("lz_d2_an", 32'(an), 32'hB);
        checkOutput("lz_d2_seg", 32'(seg), 32'h7F);
        scanDigit("lz");
        checkOutput("lz_d3_an", 32'(an), 32'h7);
        checkOutput("lz_d3_seg", 32'(seg), 32'h7F);
        scanDigit("lz");
        checkOutput("lz_d0_seg", 32'(seg), 32'h40);
        scanDigit("lz");
        checkOutput("lz_d1_seg", 32'(seg), 32'h12);

        value = 16'h1234; blank_lz = 1'b0; digit_en = 4'b1011; dp = 4'b0100;
        scanDigit("dark");
        checkOutput("dark_d2_an", 32'(an), 32'hF);
        checkOutput("dark_d2_dpn", 32'(dp_n), 32'h1);
        scanDigit("dark");
        scanDigit("dark");
        checkOutput("dark_d0_an", 32'(an), 32'hE);
        checkOutput("dark_d0_dpn", 32'(dp_n), 32'h1);

        digit_en = 4'hF; dp = 4'h0;
        scan_tick = 1'b1; applyStimulus(1);
        scan_tick = 1'b0; applyStimulus(4);
        scan_tick = 1'b1; applyStimulus(1);
        scan_tick = 1'b0; applyStimulus(10);
        checkOutput("drop_gap_an", 32'(an), 32'hF);
        applyStimulus(1);
        checkOutput("drop_an", 32'(an), 32'hD);
        checkOutput("drop_seg", 32'(seg), 32'h30);
        value = 16'hFFFF;
        applyStimulus(10);
        checkOutput("frozen_seg", 32'(seg), 32'h30);
        scanDigit("next");
        checkOutput("next_seg", 32'(seg), 32'h0E);
        checkOutput("next_sel", 32'(digit_sel), 32'h2);

        applyStimulus(2);
        rst = 1'b0;
        applyStimulus(1);
        checkOutput("abort_an", 32'(an), 32'hF);
        checkOutput("abort_seg", 32'(seg), 32'h7F);
        checkOutput("abort_dpn", 32'(dp_n), 32'h1);
        checkOutput("abort_sel", 32'(digit_sel), 32'h3);
        rst = 1'b1; value = 16'h1234;
        applyStimulus(3);
        scanDigit("restart");
        checkOutput("restart_sel", 32'(digit_sel), 32'h0);
        checkOutput("restart_an", 32'(an), 32'hE);

        for (int n = 0; n < 6000; n++) begin
            if ($urandom_range(0, 39) == 0) scan_tick = ~scan_tick;
            if ($urandom_range(0, 29) == 0)
                value = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
            if ($urandom_range(0, 49) == 0) dp = 4'($urandom);
            if ($urandom_range(0, 49) == 0) digit_en = 4'($urandom);
            if ($urandom_range(0, 49) == 0) blank_lz = 1'($urandom);
            rst = ($urandom_range(0, 599) != 0);
            applyStimulus(1);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
